// File: rtl/mem_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_seq_pkg
// Description : Shared size, error-code and state encodings for the memory
//               access sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_seq_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE   = 2'b00,
        SZ_HALF   = 2'b01,
        SZ_WORD   = 2'b10,
        SZ_DOUBLE = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        ERR_OK      = 2'b00,
        ERR_ALIGN   = 2'b01,
        ERR_TIMEOUT = 2'b10,
        ERR_SIZE    = 2'b11
    } err_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACCESS = 2'b01,
        ST_RESP   = 2'b10
    } state_e;

endpackage
`default_nettype wire

// File: rtl/mem_lane_align.sv
`default_nettype none
// ============================================================================
// Module      : mem_lane_align
// Description : Combinational byte-lane steering: store-data replication,
//               byte-enable generation, load extraction and extension.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_lane_align
    import mem_seq_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  size_e                          i_size,
    input  logic [$clog2(DATA_W/8)-1:0]    i_lane,
    input  logic                           i_unsigned,
    input  logic [DATA_W-1:0]              i_wdata,
    input  logic [DATA_W-1:0]              i_rdata,
    output logic [DATA_W-1:0]              o_wdata,
    output logic [DATA_W/8-1:0]            o_be,
    output logic [DATA_W-1:0]              o_rdata
);

    localparam int c_NB = DATA_W / 8;

    int                w_nbytes;
    int                w_mask;
    int                w_base;
    logic [DATA_W-1:0] w_shift;
    logic              w_sign;

    always_comb begin
        w_nbytes = 1;
        case (i_size)
            SZ_HALF:   w_nbytes = 2;
            SZ_WORD:   w_nbytes = 4;
            SZ_DOUBLE: w_nbytes = 8;
            default:   w_nbytes = 1;
        endcase
        // An oversize request is rejected upstream; clamping keeps indices in range.
        if (w_nbytes > c_NB) begin
            w_nbytes = c_NB;
        end
        w_mask  = w_nbytes - 1;
        w_base  = int'(i_lane) & ~w_mask;
        w_shift = i_rdata >> (8 * w_base);
        w_sign  = w_shift[8*w_nbytes-1] & ~i_unsigned;
        o_wdata = '0;
        o_be    = '0;
        o_rdata = '0;
        for (int i = 0; i < c_NB; i++) begin
            o_wdata[8*i +: 8] = i_wdata[8*(i & w_mask) +: 8];
            o_be[i]           = ((i & ~w_mask) == w_base);
        end
        for (int j = 0; j < DATA_W; j++) begin
            o_rdata[j] = (j < 8 * w_nbytes) ? w_shift[j] : w_sign;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_access_seq.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_seq
// Description : Single-outstanding load/store sequencer owning MAR/MDR and
//               the memory strobes, with a bounded MOC wait and status codes.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access_seq
    import mem_seq_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_rw,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    output logic                  rsp_valid,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic [1:0]            rsp_err,
    output logic                  mem_enable,
    output logic                  mem_rw,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic [DATA_W/8-1:0]   mem_be,
    input  logic [DATA_W-1:0]     mem_rdata,
    input  logic                  MOC,
    output logic                  busy
);

    localparam int c_NB     = DATA_W / 8;
    localparam int c_LANE_W = $clog2(c_NB);
    localparam int c_CNT_W  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT_CYC - 1);

    state_e                r_state;
    state_e                w_next_state;
    err_e                  w_req_err;
    logic [c_CNT_W-1:0]    r_cnt;
    logic [ADDR_W-1:0]     r_mar;
    logic [DATA_W-1:0]     r_mdr;
    logic [c_NB-1:0]       r_be;
    logic                  r_rw;
    size_e                 r_size;
    logic [c_LANE_W-1:0]   r_lane;
    logic                  r_unsigned;
    logic [DATA_W-1:0]     r_rdata;
    err_e                  r_err;
    size_e                 w_lane_size;
    logic [c_LANE_W-1:0]   w_lane_sel;
    logic [DATA_W-1:0]     w_wdata_rep;
    logic [c_NB-1:0]       w_be;
    logic [DATA_W-1:0]     w_rdata_ext;

    // Store steering uses the live request while idle; load extraction uses the captured one.
    assign w_lane_size = (r_state == ST_IDLE) ? size_e'(req_size) : r_size;
    assign w_lane_sel  = (r_state == ST_IDLE) ? req_addr[c_LANE_W-1:0] : r_lane;

    mem_lane_align #(
        .DATA_W (DATA_W)
    ) u_lane (
        .i_size     (w_lane_size),
        .i_lane     (w_lane_sel),
        .i_unsigned (r_unsigned),
        .i_wdata    (req_wdata),
        .i_rdata    (mem_rdata),
        .o_wdata    (w_wdata_rep),
        .o_be       (w_be),
        .o_rdata    (w_rdata_ext)
    );

    always_comb begin
        w_req_err    = ERR_OK;
        w_next_state = r_state;
        // Alignment is checked before size legality.
        case (req_size)
            2'b01: if (req_addr[0])          w_req_err = ERR_ALIGN;
            2'b10: if (req_addr[1:0] != '0)  w_req_err = ERR_ALIGN;
            2'b11: begin
                if (req_addr[2:0] != '0)     w_req_err = ERR_ALIGN;
                else if (DATA_W == 32)       w_req_err = ERR_SIZE;
            end
            default: w_req_err = ERR_OK;
        endcase
        case (r_state)
            ST_IDLE:   if (req_valid) w_next_state = (w_req_err == ERR_OK) ? ST_ACCESS : ST_RESP;
            ST_ACCESS: if (MOC || (r_cnt == c_CNT_LAST)) w_next_state = ST_RESP;
            ST_RESP:   w_next_state = ST_IDLE;
            default:   w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_next_state;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt      <= '0;
            r_mar      <= '0;
            r_mdr      <= '0;
            r_be       <= '0;
            r_rw       <= 1'b0;
            r_size     <= SZ_BYTE;
            r_lane     <= '0;
            r_unsigned <= 1'b0;
            r_rdata    <= '0;
            r_err      <= ERR_OK;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (req_valid) begin
                        r_err   <= w_req_err;
                        r_rdata <= '0;
                        r_cnt   <= '0;
                        if (w_req_err == ERR_OK) begin
                            r_mar      <= {req_addr[ADDR_W-1:c_LANE_W], {c_LANE_W{1'b0}}};
                            r_mdr      <= w_wdata_rep;
                            r_be       <= w_be;
                            r_rw       <= req_rw;
                            r_size     <= size_e'(req_size);
                            r_lane     <= req_addr[c_LANE_W-1:0];
                            r_unsigned <= req_unsigned;
                        end
                    end
                end
                ST_ACCESS: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (MOC) begin
                        r_err   <= ERR_OK;
                        r_rdata <= r_rw ? '0 : w_rdata_ext;
                    end else if (r_cnt == c_CNT_LAST) begin
                        r_err <= ERR_TIMEOUT;
                    end
                end
                default: ;
            endcase
        end
    end

    assign req_ready  = (r_state == ST_IDLE);
    assign busy       = (r_state != ST_IDLE);
    assign mem_enable = (r_state == ST_ACCESS);
    assign rsp_valid  = (r_state == ST_RESP);
    assign mem_rw     = r_rw;
    assign mem_addr   = r_mar;
    assign mem_wdata  = r_mdr;
    assign mem_be     = r_be;
    assign rsp_rdata  = rsp_valid ? r_rdata : '0;
    assign rsp_err    = rsp_valid ? r_err : ERR_OK;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_access_seq
// Description : Self-checking bench for mem_access_seq at 32- and 64-bit width.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access_seq;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_rw, req_unsigned;
    logic [1:0]  req_size;
    logic [31:0] req_addr;
    logic [63:0] req_wdata, mem_rdata;
    logic        v32, v64, moc32, moc64;

    logic        rdy32, rsv32, en32, rw32, busy32;
    logic [31:0] rsd32, addr32, wd32;
    logic [1:0]  rse32;
    logic [3:0]  be32;
    logic        rdy64, rsv64, en64, rw64, busy64;
    logic [63:0] rsd64, wd64;
    logic [31:0] addr64;
    logic [1:0]  rse64;
    logic [7:0]  be64;

    bit          sel64;
    logic        obs_ready, obs_rsp, obs_en, obs_rw, obs_busy;
    logic [63:0] obs_rdata, obs_wdata;
    logic [31:0] obs_addr;
    logic [1:0]  obs_err;
    logic [7:0]  obs_be;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mem_access_seq #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(TO)) u_dut32 (
        .clk(clk), .reset(reset), .req_valid(v32), .req_ready(rdy32), .req_rw(req_rw),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata[31:0]), .rsp_valid(rsv32), .rsp_rdata(rsd32), .rsp_err(rse32),
        .mem_enable(en32), .mem_rw(rw32), .mem_addr(addr32), .mem_wdata(wd32), .mem_be(be32),
        .mem_rdata(mem_rdata[31:0]), .MOC(moc32), .busy(busy32)
    );

    mem_access_seq #(.ADDR_W(32), .DATA_W(64), .TIMEOUT_CYC(TO)) u_dut64 (
        .clk(clk), .reset(reset), .req_valid(v64), .req_ready(rdy64), .req_rw(req_rw),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .rsp_valid(rsv64), .rsp_rdata(rsd64), .rsp_err(rse64),
        .mem_enable(en64), .mem_rw(rw64), .mem_addr(addr64), .mem_wdata(wd64), .mem_be(be64),
        .mem_rdata(mem_rdata), .MOC(moc64), .busy(busy64)
    );

    always_comb begin
        obs_ready = sel64 ? rdy64  : rdy32;
        obs_rsp   = sel64 ? rsv64  : rsv32;
        obs_en    = sel64 ? en64   : en32;
        obs_rw    = sel64 ? rw64   : rw32;
        obs_busy  = sel64 ? busy64 : busy32;
        obs_rdata = sel64 ? rsd64  : {32'b0, rsd32};
        obs_wdata = sel64 ? wd64   : {32'b0, wd32};
        obs_addr  = sel64 ? addr64 : addr32;
        obs_err   = sel64 ? rse64  : rse32;
        obs_be    = sel64 ? be64   : {4'b0, be32};
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: access rules computed directly from sizes and byte offsets.
    function automatic logic [1:0] mdl_err(input bit wide, input logic [1:0] size, input logic [31:0] addr);
        int bytes = 1 << size;
        if ((addr % bytes) != 0) return 2'b01;
        if (size == 2'b11 && !wide) return 2'b11;
        return 2'b00;
    endfunction

    function automatic logic [63:0] mdl_mask(input int bytes);
        return (bytes == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (8 * bytes)) - 64'd1);
    endfunction

    task automatic check_quiet(input string tag);
        check_val({tag, "_ready"}, obs_ready, 1);
        check_val({tag, "_busy"},  obs_busy,  0);
        check_val({tag, "_en"},    obs_en,    0);
        check_val({tag, "_rsp"},   obs_rsp,   0);
        check_val({tag, "_err"},   obs_err,   0);
        check_val({tag, "_rdata"}, obs_rdata, 0);
    endtask

    task automatic do_txn(input bit wide, input logic rw, input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [63:0] wdata, input logic [63:0] rdata,
                          input int moc_delay, input bit hold);
        int nb = wide ? 8 : 4;
        int bytes = 1 << size;
        int lane = addr % nb;
        logic [63:0] mask = mdl_mask(bytes);
        logic [63:0] wd = wide ? wdata : (wdata & 64'hFFFF_FFFF);
        logic [63:0] rd = wide ? rdata : (rdata & 64'hFFFF_FFFF);
        logic [1:0]  e_err = mdl_err(wide, size, addr);
        bit          legal = (e_err == 2'b00);
        logic [63:0] e_be = ((64'd1 << bytes) - 64'd1) << lane;
        logic [63:0] e_wd = 0;
        logic [63:0] e_rd;
        logic [31:0] e_addr = addr - lane;
        int e_rsp, e_en, en_cnt = 0, rsp_cyc = 0;
        bit hit;
        for (int k = 0; k < nb / bytes && k < 8; k++) e_wd |= (wd & mask) << (8 * bytes * k);
        e_rd = (rd >> (8 * lane)) & mask;
        if (!uns && e_rd[8*bytes-1]) e_rd |= ~mask;
        if (!wide) e_rd &= 64'hFFFF_FFFF;
        if (!legal) begin
            e_rsp = 1; e_en = 0; e_rd = 0;
        end else if (moc_delay + 1 <= TO) begin
            e_rsp = moc_delay + 2; e_en = e_rsp - 1;
            if (rw) e_rd = 0;
        end else begin
            e_rsp = TO + 1; e_en = TO; e_err = 2'b10; e_rd = 0;
        end

        sel64 = wide;
        req_rw = rw; req_size = size; req_unsigned = uns; req_addr = addr; req_wdata = wdata;
        if (wide) begin v64 = 1'b1; moc64 = 1'($urandom_range(0, 1)); end
        else      begin v32 = 1'b1; moc32 = 1'($urandom_range(0, 1)); end
        #1;
        check_val("ready_pre", obs_ready, 1);
        @(posedge clk); #1;
        if (!hold) begin
            v32 = 1'b0; v64 = 1'b0;
            req_addr = $urandom; req_wdata = {$urandom, $urandom}; req_size = 2'($urandom);
            req_rw = 1'($urandom); req_unsigned = 1'($urandom);
        end
        for (int c = 1; c <= 40 && rsp_cyc == 0; c++) begin
            hit = legal && (c == moc_delay + 1);
            mem_rdata = hit ? rd : {$urandom, $urandom};
            if (wide) begin moc64 = legal ? hit : 1'($urandom); moc32 = 1'($urandom); end
            else      begin moc32 = legal ? hit : 1'($urandom); moc64 = 1'($urandom); end
            @(negedge clk);
            check_val("busy", obs_busy, 1);
            check_val("ready_busy", obs_ready, 0);
            if (obs_en) begin
                en_cnt++;
                check_val("mem_addr", obs_addr, e_addr);
                check_val("mem_be", obs_be, e_be);
                check_val("mem_rw", obs_rw, rw);
                check_val("mem_wdata", obs_wdata, e_wd);
            end
            if (obs_rsp) begin
                rsp_cyc = c;
                check_val("rsp_err", obs_err, e_err);
                check_val("rsp_rdata", obs_rdata, e_rd);
                check_val("en_in_rsp", obs_en, 0);
            end else begin
                check_val("err_idle", obs_err, 0);
                check_val("rdata_idle", obs_rdata, 0);
            end
            @(posedge clk); #1;
        end
        check_val("rsp_cycle", rsp_cyc, e_rsp);
        check_val("enable_cycles", en_cnt, e_en);
        moc32 = 1'b0; moc64 = 1'b0;
        @(negedge clk);
        check_quiet("post");
    endtask

    task automatic reset_mid(input bit wide);
        sel64 = wide;
        req_rw = 1'b0; req_size = 2'b10; req_unsigned = 1'b0; req_addr = 32'h40; req_wdata = 64'h1;
        if (wide) v64 = 1'b1; else v32 = 1'b1;
        @(posedge clk); #1;
        v32 = 1'b0; v64 = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1; moc32 = 1'b1; moc64 = 1'b1; mem_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
        @(negedge clk);
        check_val("rst_mid_en_before", obs_en, 1);
        @(posedge clk); #1;
        reset = 1'b0; moc32 = 1'b0; moc64 = 1'b0;
        @(negedge clk);
        check_quiet("rst_mid");
        check_val("rst_mid_addr", obs_addr, 0);
        @(negedge clk);
        check_val("rst_mid_rsp_late", obs_rsp, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  sz;
        logic [31:0] a;
        bit          w;
        reset = 1'b1; moc32 = 1'b0; moc64 = 1'b0; mem_rdata = '0;
        req_rw = 1'b1; req_size = 2'b10; req_unsigned = 1'b0; req_addr = 32'h100; req_wdata = 64'h55;
        v32 = 1'b1; v64 = 1'b1;
        repeat (3) @(posedge clk);
        for (int s = 0; s < 2; s++) begin
            sel64 = bit'(s);
            @(negedge clk);
            check_quiet("reset");
            check_val("reset_addr", obs_addr, 0);
            check_val("reset_be", obs_be, 0);
            check_val("reset_wdata", obs_wdata, 0);
            check_val("reset_rw", obs_rw, 0);
        end
        v32 = 1'b0; v64 = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_val("no_accept_in_reset", busy32 | busy64, 0);

        do_txn(0, 1, 2'b10, 0, 32'h104, 64'hDEAD_BEEF, 0, 1, 0);
        do_txn(0, 0, 2'b00, 0, 32'h203, 0, 64'h80FF_1234, 2, 0);
        do_txn(0, 0, 2'b00, 1, 32'h203, 0, 64'h80FF_1234, 0, 0);
        do_txn(0, 0, 2'b01, 0, 32'h001, 0, 0, 0, 0);
        do_txn(0, 0, 2'b10, 0, 32'h010, 0, 64'h1234, 100, 0);
        do_txn(0, 0, 2'b01, 0, 32'h012, 0, 64'h8001_0000, TO - 1, 0);
        do_txn(0, 0, 2'b11, 0, 32'h008, 0, 0, 0, 0);
        do_txn(0, 0, 2'b11, 0, 32'h004, 0, 0, 0, 0);
        do_txn(1, 0, 2'b11, 0, 32'h008, 0, 64'h0123_4567_89AB_CDEF, 0, 0);
        do_txn(1, 1, 2'b10, 0, 32'h00C, 64'hCAFE_F00D, 0, 1, 0);
        do_txn(1, 0, 2'b10, 0, 32'h00C, 0, 64'h9000_0000_0000_0000, 3, 0);
        do_txn(1, 0, 2'b11, 0, 32'h004, 0, 0, 0, 0);
        reset_mid(0);
        reset_mid(1);
        do_txn(0, 1, 2'b00, 0, 32'h007, 64'hA5, 0, 0, 1);
        do_txn(0, 1, 2'b00, 0, 32'h007, 64'hA5, 0, 0, 0);
        do_txn(1, 0, 2'b01, 1, 32'h00E, 0, 64'h8765_4321_0000_0000, 1, 1);
        do_txn(1, 0, 2'b01, 1, 32'h00E, 0, 64'h8765_4321_0000_0000, 1, 0);

        for (int n = 0; n < 200; n++) begin
            w  = 1'($urandom);
            sz = 2'($urandom);
            a  = $urandom;
            if ($urandom_range(0, 3) != 0) a = a & ~((32'd1 << sz) - 32'd1);
            do_txn(w, 1'($urandom), sz, 1'($urandom), a, {$urandom, $urandom}, {$urandom, $urandom},
                   int'($urandom_range(0, TO + 1)), 0);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_access_seq.md
# mem_access_seq

Parametrised memory-access sequencer between the multicycle datapath controller and the MOC-handshaked data memory. Accepts one load/store request at a time and owns MAR/MDR and the memory enable/RW strobes. Steers byte/halfword/word (and doubleword at 64-bit width) lanes, sign- or zero-extends loads, and rejects misaligned or oversize accesses. Bounds every MOC wait with a timeout and returns a status code, so the control FSM no longer stalls forever on a missing MOC.

## Interface
- ADDR_W, 32, address width.
- DATA_W, 32, memory data width; legal values 32 or 64.
- TIMEOUT_CYC, 16, maximum cycles spent in ACCESS waiting for MOC; minimum 1.
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  high only in IDLE; a request transfers on a rising edge with req_valid & req_ready.
- req_rw  in  1  0 = load, 1 = store.
- req_size  in  2  00 byte, 01 half, 10 word, 11 doubleword (legal only when DATA_W = 64).
- req_unsigned  in  1  load zero-extends when 1, sign-extends when 0.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  DATA_W  store data, right-justified.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  DATA_W  extended load data; 0 for stores and errors.
- rsp_err  out  2  00 ok, 01 misaligned, 10 timeout, 11 illegal size.
- mem_enable  out  1  memory strobe.
- mem_rw  out  1  0 read, 1 write.
- mem_addr  out  ADDR_W  MAR; word-aligned (low log2(DATA_W/8) bits zero).
- mem_wdata  out  DATA_W  MDR, lane-replicated.
- mem_be  out  DATA_W/8  byte enables; bit i = byte lane i.
- mem_rdata  in  DATA_W  memory read data, valid when MOC is high.
- MOC  in  1  memory operation complete.
- busy  out  1  high when the state is not IDLE.

## Operation
- States are IDLE, ACCESS and RESP.
- **IDLE**
  - On accept, check alignment first, then size.
  - Misaligned: half with addr[0] ≠ 0; word with addr[1:0] ≠ 0; double with addr[2:0] ≠ 0.
  - Illegal size: 11 when DATA_W = 32.
  - Error: go to RESP with that code. Memory is never enabled.
  - Legal request:
    - Load MAR with the aligned address, MDR with replicated wdata, and mem_be and mem_rw.
    - Clear the timeout counter and go to ACCESS.
- **ACCESS**
  - mem_enable = 1; mem_rw, mem_addr, mem_be and mem_wdata are held stable.
  - The counter increments each cycle.
  - MOC = 1 at an edge: capture data, go to RESP with err 00.
  - Otherwise, counter = TIMEOUT_CYC - 1: go to RESP with err 10.
  - MOC and timeout on the same edge: MOC wins.
- **RESP**
  - rsp_valid = 1 and mem_enable = 0; go to IDLE on the next edge.
- **Lane rules** (little-endian; lane index = addr[log2(DATA_W/8)-1:0])
  - Byte: replicate wdata[7:0] to every lane; be is one-hot at the lane.
  - Half: replicate wdata[15:0]; be covers 2 lanes.
  - Word at DATA_W = 64: replicate wdata[31:0]; be covers 4 lanes.
  - Full width: be is all ones.
  - Load: extract the selected lanes from mem_rdata, then extend per req_unsigned to DATA_W.
- A request presented in a non-IDLE state is not accepted. The requester holds it until req_ready is high.

## Timing
- **Reset** (synchronous): state goes to IDLE, the counter clears, and every output except req_ready is 0. req_ready = 1 in IDLE, including the first cycle after reset.
- A request presented in a cycle where reset is high is not accepted.
- **Reset mid-ACCESS**: mem_enable is 0 after that edge and no rsp_valid is issued. A MOC arriving in the same cycle is ignored.
- **Latency**:
  - Request accepted at edge 0; mem_enable is high from the cycle after edge 0.
  - MOC is sampled at edge k ≥ 1; rsp_valid is high in the cycle after edge k.
  - req_ready returns after edge k+1.
  - Minimum request-to-request period is 3 cycles.
- **Error path**: rsp_valid is high in the cycle after accept; period 2 cycles.
- **Timeout**: rsp_valid is asserted exactly TIMEOUT_CYC+1 cycles after accept when MOC never arrives.
- **Response fields**: rsp_rdata and rsp_err are valid only while rsp_valid is high, and are 0 otherwise.
- **MOC outside ACCESS** is ignored.

## Structure
- Shared package mem_seq_pkg holds:
  - the size enum (SZ_BYTE, SZ_HALF, SZ_WORD, SZ_DOUBLE);
  - the error enum (ERR_OK, ERR_ALIGN, ERR_TIMEOUT, ERR_SIZE);
  - the state enum.
- One combinational sub-module, mem_lane_align, handles:
  - wdata replication and be generation;
  - load lane extraction and extension.
  It is parametrised by DATA_W.
- The top level holds the FSM, MAR/MDR registers, timeout counter and response registers.

## Test plan
- Word store: DATA_W = 32, addr 0x104, wdata 0xDEADBEEF, MOC after 2 cycles → mem_addr 0x104, mem_be 1111, mem_rw 1, rsp_err 00, rsp_valid 1 cycle.
- Signed byte load: addr 0x203, mem_rdata 0x80FF_1234 → mem_be 1000; rsp_rdata 0xFFFFFF80; repeated with req_unsigned = 1 → 0x00000080.
- Misaligned half load: addr 0x001 → rsp_err 01 in the cycle after accept; mem_enable never rises.
- Timeout: TIMEOUT_CYC = 4, MOC held low → rsp_err 10, rsp_valid 5 cycles after accept; mem_enable high exactly 4 cycles.
- Size rules: req_size 11 at DATA_W = 32 → rsp_err 11. Double load at DATA_W = 64, addr 0x8 → be 0xFF, err 00.
- Reset and handshake corner cases:
  - reset asserted in the 2nd ACCESS cycle → no rsp_valid, busy 0, req_ready 1 after that edge.
  - A request held during busy is accepted only on the cycle after RESP.
